branch_flush_controller: RTL and testbench
==========================================

# branch_flush_controller

Branch-resolution controller for the 5-stage RISC-V pipeline. Consumes the EX-stage branch decision from the branching unit, compares it against the prediction made in ID, and sequences the PC redirect and the IF/ID + ID/EX squash. Optionally hosts a 2-bit-counter branch history table (BHT) that supplies predictions to ID. Keeps branch and mispredict statistics counters.

## Interface
Parameters:
- BHT_ENTRIES, 16: BHT depth, power of two; index = id_pc/ex_pc bits [log2(BHT_ENTRIES)+1:2].
- FLUSH_CYCLES, 2: number of cycles flush is asserted per mispredict, ≥1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- id_branch  in  1  conditional branch present in ID.
- id_pc  in  32  PC of ID instruction.
- pred_taken  out  1  prediction for the ID branch, combinational.
- stall  in  1  pipeline hold; freezes all state in this block.
- ex_branch  in  1  conditional branch valid in EX.
- ex_pc  in  32  PC of EX instruction.
- ex_target  in  32  computed branch target.
- ex_taken  in  1  resolved outcome from the branching unit.
- ex_pred_taken  in  1  prediction carried down the pipe with the instruction.
- redirect  out  1  fetch must load redirect_pc.
- redirect_pc  out  32  corrected fetch address.
- flush  out  1  clear IF/ID and ID/EX at next edge.
- br_count  out  32  resolved branches.
- mp_count  out  32  mispredicts.

## Operation
- mispredict = ex_branch & (ex_taken != ex_pred_taken) & ~stall & (state == RUN).
- redirect = mispredict; redirect_pc = ex_taken ? ex_target : ex_pc + 4 (32-bit wrap, carry dropped).
- FSM states RUN, SQUASH; 2-bit-wide down-counter sq_cnt.
- RUN: flush = mispredict. On mispredict with FLUSH_CYCLES > 1 → SQUASH, sq_cnt = FLUSH_CYCLES-2; otherwise stay RUN.
- SQUASH: flush = 1, redirect = 0, ex_branch ignored (no update, no count, no mispredict). If sq_cnt == 0 → RUN, else sq_cnt--. stall high holds state and sq_cnt; flush stays high.
- Resolve event = ex_branch & ~stall & state == RUN. On resolve: br_count++; if mispredict, mp_count++. Both saturate at 32'hFFFF_FFFF.
- BHT (when compiled in): 2-bit counters, value ≥2 = taken. pred_taken = bht[id_pc index][1] & id_branch. On resolve: entry at ex_pc index increments if ex_taken (saturate 3), else decrements (saturate 0).
- Same-index read and write in one cycle: read returns the pre-update value, no bypass.

## Timing
- Reset: state = RUN, sq_cnt = 0, flush = 0, redirect = 0, redirect_pc = 0 when ex inputs are 0, br_count = 0, mp_count = 0, every BHT entry = 2'b01.
- Reset mid-SQUASH returns to RUN immediately; flush drops asynchronously.
- redirect/flush: 0-cycle latency from EX inputs (combinational in the detect cycle). With FLUSH_CYCLES = N, flush is high for exactly N consecutive non-stalled cycles.
- Counters and BHT update at the rising edge ending the resolve cycle; visible on the next cycle.
- Mispredict arriving while stall = 1 is deferred until stall = 0. The EX instruction is held, so it is detected once, not lost.

## Configuration
- BRANCH_PREDICT_EN defined: BHT instantiated as above.
- Not defined: no BHT storage; pred_taken = 0 constant (static not-taken). Every taken branch mispredicts, assuming ex_pred_taken = 0 from the pipe. Counters and FSM are unchanged.

## Test plan
- Reset then ex_branch=1, ex_pc=0x100, ex_target=0x80, ex_taken=1, ex_pred_taken=0 -> same cycle redirect=1, redirect_pc=0x80, flush=1. Next cycle flush=1 (SQUASH), then 0. br_count=1, mp_count=1.
- Predicted taken, actually not taken at ex_pc=0xFFFF_FFFC -> redirect_pc=0x0000_0000 (wrap).
- Correct prediction (taken=pred=1) -> redirect=0, flush=0, br_count increments, mp_count unchanged.
- BRANCH_PREDICT_EN: resolve taken twice at ex_pc=0x40. Then id_branch=1, id_pc=0x40 -> pred_taken=1. Then two not-taken resolves -> pred_taken=0. Aliased id_pc=0x80 with 16 entries shares the entry.
- Mispredict with stall=1 for 3 cycles -> redirect held 0 and counters unchanged until stall=0, then exactly one mispredict is counted. A stall during SQUASH extends flush by the stall length.
- Assert rst during SQUASH -> flush=0 without a clock edge, counters=0, BHT entries read 2'b01.

Source files
------------

// File: rtl/branch_flush_if.sv
// Bundle between the pipeline (ID/EX/fetch) and the branch flush controller.
// master = pipeline side, slave = branch_flush_controller.
interface branch_flush_if;
  logic        id_branch;
  logic [31:0] id_pc;
  logic        pred_taken;
  logic        stall;
  logic        ex_branch;
  logic [31:0] ex_pc;
  logic [31:0] ex_target;
  logic        ex_taken;
  logic        ex_pred_taken;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        flush;
  logic [31:0] br_count;
  logic [31:0] mp_count;

  modport master (
    output id_branch, id_pc, stall,
    output ex_branch, ex_pc, ex_target,
    output ex_taken, ex_pred_taken,
    input  pred_taken, redirect, redirect_pc,
    input  flush, br_count, mp_count
  );

  modport slave (
    input  id_branch, id_pc, stall,
    input  ex_branch, ex_pc, ex_target,
    input  ex_taken, ex_pred_taken,
    output pred_taken, redirect, redirect_pc,
    output flush, br_count, mp_count
  );
endinterface

// File: rtl/branch_flush_controller.sv
// Branch resolution, PC redirect and IF/ID+ID/EX squash sequencing.
// Define BRANCH_PREDICT_EN to build the 2-bit-counter BHT; else static not-taken.
module branch_flush_controller #(
  parameter int BHT_ENTRIES  = 16,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  branch_flush_if.slave bus
);
  localparam int IDX = $clog2(BHT_ENTRIES);
  localparam logic [1:0] SQ_INIT = 2'(FLUSH_CYCLES - 2);

  typedef enum logic [0:0] {RUN, SQUASH} state_t;

  state_t      state;
  logic [1:0]  sq_cnt;
  logic [31:0] br_q;
  logic [31:0] mp_q;
  logic        run;
  logic        resolve;
  logic        mispredict;
  logic [31:0] fix_pc;

  // rst gating keeps redirect/flush low while reset is held
  assign run        = (state == RUN) & ~rst;
  assign resolve    = bus.ex_branch & ~bus.stall & run;
  assign mispredict = resolve & (bus.ex_taken != bus.ex_pred_taken);
  assign fix_pc     = bus.ex_taken ? bus.ex_target
                                   : bus.ex_pc + 32'd4;

  assign bus.redirect    = mispredict;
  assign bus.redirect_pc = mispredict ? fix_pc : 32'd0;
  assign bus.flush       = mispredict | (state == SQUASH);
  assign bus.br_count    = br_q;
  assign bus.mp_count    = mp_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= RUN;
      sq_cnt <= 2'd0;
    end else if (!bus.stall) begin
      case (state)
        RUN: begin
          if (mispredict && FLUSH_CYCLES > 1) begin
            state  <= SQUASH;
            sq_cnt <= SQ_INIT;
          end
        end
        SQUASH: begin
          if (sq_cnt == 2'd0) begin
            state <= RUN;
          end else begin
            sq_cnt <= sq_cnt - 2'd1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_q <= 32'd0;
      mp_q <= 32'd0;
    end else if (resolve) begin
      if (br_q != 32'hFFFF_FFFF) begin
        br_q <= br_q + 32'd1;
      end
      if (mispredict && mp_q != 32'hFFFF_FFFF) begin
        mp_q <= mp_q + 32'd1;
      end
    end
  end

`ifdef BRANCH_PREDICT_EN
  logic [1:0]     bht [BHT_ENTRIES];
  logic [IDX-1:0] rd_idx;
  logic [IDX-1:0] wr_idx;
  logic           unused_id;

  assign rd_idx    = bus.id_pc[IDX+1:2];
  assign wr_idx    = bus.ex_pc[IDX+1:2];
  assign unused_id = ^{bus.id_pc[31:IDX+2], bus.id_pc[1:0]};

  // read sees the pre-update counter on a same-index collision
  assign bus.pred_taken = bht[rd_idx][1] & bus.id_branch;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht[i] <= 2'b01;
      end
    end else if (resolve) begin
      if (bus.ex_taken) begin
        if (bht[wr_idx] != 2'b11) begin
          bht[wr_idx] <= bht[wr_idx] + 2'b01;
        end
      end else begin
        if (bht[wr_idx] != 2'b00) begin
          bht[wr_idx] <= bht[wr_idx] - 2'b01;
        end
      end
    end
  end
`else
  logic unused_id;

  assign unused_id      = ^{bus.id_pc, bus.id_branch};
  assign bus.pred_taken = 1'b0;
`endif

endmodule

// File: tb/tb_branch_flush_controller.sv
// Directed bench for branch_flush_controller with an expectation queue.
// Prediction checks follow BRANCH_PREDICT_EN; default FLUSH_CYCLES = 2.
module tb_branch_flush_controller;
`ifdef BRANCH_PREDICT_EN
  localparam logic BP = 1'b1;
`else
  localparam logic BP = 1'b0;
`endif

  typedef struct {
    string       tag;
    logic        rd;
    logic [31:0] rpc;
    logic        fl;
    logic        pr;
    logic [31:0] br;
    logic [31:0] mp;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  exp_t sb [$];

  branch_flush_if bif ();

  branch_flush_controller #(
    .BHT_ENTRIES (16),
    .FLUSH_CYCLES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(
    input string tag, input logic rd, input logic [31:0] rpc,
    input logic fl, input logic pr,
    input logic [31:0] br, input logic [31:0] mp);
    exp_t e;
    e.tag = tag; e.rd = rd; e.rpc = rpc; e.fl = fl;
    e.pr = pr; e.br = br; e.mp = mp;
    return e;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic compare();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = sb.pop_front();
      chk({e.tag, ".redirect"},    {31'd0, bif.redirect},   {31'd0, e.rd});
      chk({e.tag, ".redirect_pc"}, bif.redirect_pc,         e.rpc);
      chk({e.tag, ".flush"},       {31'd0, bif.flush},      {31'd0, e.fl});
      chk({e.tag, ".pred_taken"},  {31'd0, bif.pred_taken}, {31'd0, e.pr});
      chk({e.tag, ".br_count"},    bif.br_count,            e.br);
      chk({e.tag, ".mp_count"},    bif.mp_count,            e.mp);
    end
  endtask

  task automatic step(
    input logic b, input logic [31:0] pc, input logic [31:0] tg,
    input logic tk, input logic pt, input logic st,
    input logic ib, input logic [31:0] ip, input exp_t e);
    @(negedge clk);
    bif.ex_branch     = b;
    bif.ex_pc         = pc;
    bif.ex_target     = tg;
    bif.ex_taken      = tk;
    bif.ex_pred_taken = pt;
    bif.stall         = st;
    bif.id_branch     = ib;
    bif.id_pc         = ip;
    sb.push_back(e);
    #2;
    compare();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bif.ex_branch = 0; bif.ex_pc = 0; bif.ex_target = 0;
    bif.ex_taken = 0; bif.ex_pred_taken = 0; bif.stall = 0;
    bif.id_branch = 0; bif.id_pc = 0;

    step(0, 0, 0, 0, 0, 0, 0, 0, mk("reset", 0, 0, 0, 0, 0, 0));
    rst = 1'b0;

    step(1, 32'h104, 32'h80, 1, 0, 0, 0, 0, mk("mp_detect", 1, 32'h80, 1, 0, 0, 0));
    step(1, 32'h104, 32'h80, 1, 0, 0, 0, 0, mk("squash", 0, 0, 1, 0, 1, 1));
    step(0, 0, 0, 0, 0, 0, 0, 0, mk("squash_end", 0, 0, 0, 0, 1, 1));

    step(1, 32'hFFFF_FFFC, 32'h1234, 0, 1, 0, 0, 0, mk("wrap", 1, 32'h0, 1, 0, 1, 1));
    step(0, 0, 0, 0, 0, 0, 0, 0, mk("wrap_squash", 0, 0, 1, 0, 2, 2));

    step(1, 32'h208, 32'h300, 1, 1, 0, 0, 0, mk("correct", 0, 0, 0, 0, 2, 2));
    step(0, 0, 0, 0, 0, 0, 0, 0, mk("correct_cnt", 0, 0, 0, 0, 3, 2));

    step(0, 0, 0, 0, 0, 0, 1, 32'h40, mk("bht_init", 0, 0, 0, 0, 3, 2));
    step(1, 32'h40, 32'h100, 1, 1, 0, 1, 32'h40, mk("bht_t1", 0, 0, 0, 0, 3, 2));
    step(1, 32'h40, 32'h100, 1, 1, 0, 1, 32'h40, mk("bht_t2", 0, 0, 0, BP, 4, 2));
    step(0, 0, 0, 0, 0, 0, 1, 32'h40, mk("bht_taken", 0, 0, 0, BP, 5, 2));
    step(0, 0, 0, 0, 0, 0, 1, 32'h80, mk("bht_alias", 0, 0, 0, BP, 5, 2));
    step(0, 0, 0, 0, 0, 0, 0, 32'h40, mk("bht_noid", 0, 0, 0, 0, 5, 2));
    step(1, 32'h40, 32'h100, 0, 0, 0, 1, 32'h40, mk("bht_n1", 0, 0, 0, BP, 5, 2));
    step(1, 32'h40, 32'h100, 0, 0, 0, 1, 32'h40, mk("bht_n2", 0, 0, 0, BP, 6, 2));
    step(0, 0, 0, 0, 0, 0, 1, 32'h40, mk("bht_nt", 0, 0, 0, 0, 7, 2));

    for (int i = 0; i < 3; i++) begin
      step(1, 32'h308, 32'h500, 1, 0, 1, 0, 0, mk("stall_hold", 0, 0, 0, 0, 7, 2));
    end
    step(1, 32'h308, 32'h500, 1, 0, 0, 0, 0, mk("stall_rel", 1, 32'h500, 1, 0, 7, 2));
    step(0, 0, 0, 0, 0, 1, 0, 0, mk("sq_stall1", 0, 0, 1, 0, 8, 3));
    step(0, 0, 0, 0, 0, 1, 0, 0, mk("sq_stall2", 0, 0, 1, 0, 8, 3));
    step(0, 0, 0, 0, 0, 0, 0, 0, mk("sq_last", 0, 0, 1, 0, 8, 3));
    step(0, 0, 0, 0, 0, 0, 0, 0, mk("sq_done", 0, 0, 0, 0, 8, 3));

    step(1, 32'h40, 32'h600, 1, 0, 0, 0, 0, mk("mp2", 1, 32'h600, 1, 0, 8, 3));
    step(0, 0, 0, 0, 0, 0, 1, 32'h40, mk("mp2_squash", 0, 0, 1, BP, 9, 4));

    rst = 1'b1;
    sb.push_back(mk("async_rst", 0, 0, 0, 0, 0, 0));
    #1;
    compare();

    step(0, 0, 0, 0, 0, 0, 1, 32'h40, mk("rst_held", 0, 0, 0, 0, 0, 0));
    rst = 1'b0;
    step(0, 0, 0, 0, 0, 0, 1, 32'h40, mk("post_rst", 0, 0, 0, 0, 0, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
